// File: rtl/cruise_pkg.sv
// Shared state encodings and default tuning constants for the cruise-control slice.
package cruise_pkg;

  typedef enum logic [1:0] {
    ST_OFF     = 2'b00,
    ST_CRUISE  = 2'b01,
    ST_STANDBY = 2'b10
  } cruise_state_e;

  localparam int unsigned MIN_CRUISE = 45;
  localparam int unsigned MAX_SPEED  = 250;
  localparam int unsigned BRAKE_DEC  = 2;

endpackage

// File: rtl/cruise_speed_model.sv
// Vehicle-speed register: brake, throttle, cruise-hold tracking or drag, all saturating.
module cruise_speed_model #(
  parameter int unsigned SPEED_W   = 8,
  parameter int unsigned MAX_SPEED = 250,
  parameter int unsigned BRAKE_DEC = 2
) (
  input  logic               clk,
  input  logic               clear_n,
  input  logic               brake,
  input  logic               throttle,
  input  logic               hold,
  input  logic [SPEED_W-1:0] target,
  output logic [SPEED_W-1:0] speed
);

  localparam logic [SPEED_W:0] DEC_X = (SPEED_W + 1)'(BRAKE_DEC);
  localparam logic [SPEED_W:0] MAX_X = (SPEED_W + 1)'(MAX_SPEED);
  localparam logic [SPEED_W:0] ONE_X = (SPEED_W + 1)'(1);

  logic [SPEED_W-1:0] speed_q, speed_d;
  logic [SPEED_W:0]   wide, diff, sum, drag;

  always_comb begin
    wide    = {1'b0, speed_q};
    diff    = wide - DEC_X;
    sum     = wide + ONE_X;
    drag    = wide - ONE_X;
    speed_d = speed_q;
    // A set top bit in the extended difference means the subtraction went below zero.
    if (brake) begin
      speed_d = diff[SPEED_W] ? '0 : diff[SPEED_W-1:0];
    end else if (throttle) begin
      speed_d = (sum > MAX_X) ? MAX_X[SPEED_W-1:0] : sum[SPEED_W-1:0];
    end else if (hold) begin
      if (speed_q < target)      speed_d = sum[SPEED_W-1:0];
      else if (speed_q > target) speed_d = drag[SPEED_W-1:0];
    end else begin
      speed_d = drag[SPEED_W] ? '0 : drag[SPEED_W-1:0];
    end
  end

  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) speed_q <= '0;
    else          speed_q <= speed_d;
  end

  assign speed = speed_q;

endmodule

// File: rtl/cruise_controller.sv
// Cruise sequencing FSM and set-point register; the speed model is a sub-module.
module cruise_controller
  import cruise_pkg::*;
#(
  parameter int unsigned SPEED_W    = 8,
  parameter int unsigned MIN_CRUISE = cruise_pkg::MIN_CRUISE,
  parameter int unsigned MAX_SPEED  = cruise_pkg::MAX_SPEED,
  parameter int unsigned BRAKE_DEC  = cruise_pkg::BRAKE_DEC
) (
  input  logic               clk,
  input  logic               clear_n,
  input  logic               off,
  input  logic               brake,
  input  logic               cancel,
  input  logic               set,
  input  logic               resume,
  input  logic               accel,
  input  logic               coast,
  input  logic               throttle,
  output logic [SPEED_W-1:0] speed,
  output logic [SPEED_W-1:0] cruise_speed,
  output logic [1:0]         cruise_state,
  output logic               cruise_active
);

  localparam logic [SPEED_W:0]   MAX_X = (SPEED_W + 1)'(MAX_SPEED);
  localparam logic [SPEED_W:0]   MIN_X = (SPEED_W + 1)'(MIN_CRUISE);
  localparam logic [SPEED_W:0]   ONE_X = (SPEED_W + 1)'(1);
  localparam logic [SPEED_W-1:0] MIN_N = SPEED_W'(MIN_CRUISE);

  cruise_state_e      state_q, state_d;
  logic [SPEED_W-1:0] cs_q, cs_d;
  logic               active_q, active_d;
  logic [SPEED_W:0]   cs_inc, cs_dec;
  logic               speed_ok;

  cruise_speed_model #(
    .SPEED_W  (SPEED_W),
    .MAX_SPEED(MAX_SPEED),
    .BRAKE_DEC(BRAKE_DEC)
  ) u_speed (
    .clk     (clk),
    .clear_n (clear_n),
    .brake   (brake),
    .throttle(throttle),
    .hold    (state_q == ST_CRUISE),
    .target  (cs_q),
    .speed   (speed)
  );

  always_comb begin
    state_d  = state_q;
    cs_d     = cs_q;
    speed_ok = (speed >= MIN_N);
    cs_inc   = {1'b0, cs_q} + ONE_X;
    cs_dec   = {1'b0, cs_q} - ONE_X;
    case (state_q)
      ST_OFF: begin
        // Higher-priority commands pre-empt set, so they simply leave OFF in place.
        if (!off && !brake && !cancel && set && speed_ok) begin
          state_d = ST_CRUISE;
          cs_d    = speed;
        end
      end
      ST_CRUISE: begin
        if (off)                  state_d = ST_OFF;
        else if (brake || cancel) state_d = ST_STANDBY;
        else if (set)             cs_d = speed;
        else if (resume)          cs_d = cs_q;
        else if (accel)           cs_d = (cs_inc > MAX_X) ? MAX_X[SPEED_W-1:0] : cs_inc[SPEED_W-1:0];
        else if (coast)           cs_d = (cs_dec[SPEED_W] || cs_dec < MIN_X) ? MIN_N : cs_dec[SPEED_W-1:0];
      end
      ST_STANDBY: begin
        if (off) begin
          state_d = ST_OFF;
        end else if (brake || cancel) begin
          state_d = ST_STANDBY;
        end else if (set) begin
          if (speed_ok) begin
            state_d = ST_CRUISE;
            cs_d    = speed;
          end
        end else if (resume && cs_q >= MIN_N) begin
          state_d = ST_CRUISE;
        end
      end
      default: state_d = ST_OFF;
    endcase
    if (state_d == ST_OFF) cs_d = '0;
    active_d = (state_d == ST_CRUISE);
  end

  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      state_q  <= ST_OFF;
      cs_q     <= '0;
      active_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cs_q     <= cs_d;
      active_q <= active_d;
    end
  end

  assign cruise_speed  = cs_q;
  assign cruise_state  = state_q;
  assign cruise_active = active_q;

endmodule
